// File: rtl/osc_tick_gen.sv
// rtl/osc_tick_gen.sv - multi-channel programmable tick generator with valid/ready config port
// Optional square-wave outputs built when OSC_TICK_GEN_CLKOUT_EN is defined.
module osc_tick_gen #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_EN,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] RUNNING,
  output logic [NUM_CH-1:0] CLKOUT
);

  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_d  [NUM_CH];
  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  pdiv_q [NUM_CH];
  logic [DIV_W-1:0]  pdiv_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] hit;
  logic              ch_ok;
  logic              pend_sel;
  logic              accept;
  logic [DIV_W-1:0]  new_div;

  // Request decode: out-of-range channels never see a pending lookup or a hit.
  always_comb begin
    ch_ok    = 32'(CFG_CH) < 32'(NUM_CH);
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CFG_CH == CH_W'(i)) pend_sel = pend_q[i];
    end
    CFG_READY = ch_ok & (~pend_sel | ~CFG_EN);
    accept    = CFG_VALID & CFG_READY;
    new_div   = (CFG_DIV == '0) ? DIV_W'(1) : CFG_DIV;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = accept && (CFG_CH == CH_W'(i));
    end
  end

  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      pdiv_d[i] = pdiv_q[i];
      if (hit[i] && !CFG_EN) begin
        en_d[i]   = 1'b0;
        pend_d[i] = 1'b0;
        cnt_d[i]  = div_q[i] - DIV_W'(1);
      end else begin
        if (en_q[i]) begin
          if (cnt_q[i] == '0) begin
            tick_d[i] = 1'b1;
            if (pend_q[i]) begin
              div_d[i]  = pdiv_q[i];
              cnt_d[i]  = pdiv_q[i] - DIV_W'(1);
              pend_d[i] = 1'b0;
            end else begin
              cnt_d[i]  = div_q[i] - DIV_W'(1);
            end
          end else begin
            cnt_d[i] = cnt_q[i] - DIV_W'(1);
          end
        end
        // A change on a running channel is parked until its next terminal count.
        if (hit[i]) begin
          if (!en_q[i]) begin
            div_d[i] = new_div;
            cnt_d[i] = new_div - DIV_W'(1);
            en_d[i]  = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
            pdiv_d[i] = new_div;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      en_q   <= '0;
      pend_q <= '0;
      tick_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= DIV_W'(DEF_DIV);
        cnt_q[i]  <= DIV_W'(DEF_DIV - 1);
        pdiv_q[i] <= DIV_W'(DEF_DIV);
      end
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
    end
  end

  assign TICK    = tick_q;
  assign RUNNING = en_q;

`ifdef OSC_TICK_GEN_CLKOUT_EN
  logic [NUM_CH-1:0] clkout_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      clkout_q <= '0;
    end else begin
      clkout_q <= clkout_q ^ tick_d;
    end
  end

  assign CLKOUT = clkout_q;
`else
  assign CLKOUT = '0;
`endif

endmodule

// File: tb/tb_osc_tick_gen.sv
// tb/tb_osc_tick_gen.sv - scoreboard bench for osc_tick_gen against a tick-schedule reference model
module tb_osc_tick_gen;

  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 200;
  localparam int CH_W    = 2;

  logic              CLK = 1'b0;
  logic              RESETN;
  logic              CFG_VALID;
  logic              CFG_READY;
  logic [CH_W-1:0]   CFG_CH;
  logic [DIV_W-1:0]  CFG_DIV;
  logic              CFG_EN;
  logic [NUM_CH-1:0] TICK;
  logic [NUM_CH-1:0] RUNNING;
  logic [NUM_CH-1:0] CLKOUT;

  osc_tick_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .CLK(CLK), .RESETN(RESETN), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV), .CFG_EN(CFG_EN),
    .TICK(TICK), .RUNNING(RUNNING), .CLKOUT(CLKOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] clk;
  } obs_t;

  obs_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Reference model: absolute cycle of the next tick per channel, not a counter.
  bit     m_run  [NUM_CH];
  bit     m_pend [NUM_CH];
  bit     m_par  [NUM_CH];
  int     m_per  [NUM_CH];
  int     m_pper [NUM_CH];
  longint m_nxt  [NUM_CH];
  longint cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_pend[i] = 0; m_par[i] = 0;
      m_per[i] = DEF_DIV; m_pper[i] = DEF_DIV; m_nxt[i] = 0;
    end
  endtask

  task automatic step(input bit v, input int ch, input int div, input bit en);
    bit   rdy, acc, tk, was_run;
    int   d;
    obs_t e;
    @(negedge CLK);
    CFG_VALID = v; CFG_CH = CH_W'(ch); CFG_DIV = DIV_W'(div); CFG_EN = en;
    #1;
    rdy = (ch < NUM_CH) ? (!m_pend[ch] || !en) : 1'b0;
    check("cfg_ready", 32'(CFG_READY), 32'(rdy));
    acc = v && rdy;
    d   = (div == 0) ? 1 : div;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      tk = 0;
      was_run = m_run[i];
      if (acc && ch == i && !en) begin
        m_run[i] = 0; m_pend[i] = 0;
      end else begin
        if (was_run && cyc == m_nxt[i]) begin
          tk = 1;
          if (m_pend[i]) begin m_per[i] = m_pper[i]; m_pend[i] = 0; end
          m_nxt[i] = cyc + m_per[i];
        end
        if (acc && ch == i) begin
          if (!was_run) begin m_run[i] = 1; m_per[i] = d; m_nxt[i] = cyc + d; end
          else begin m_pend[i] = 1; m_pper[i] = d; end
        end
      end
      if (tk) m_par[i] = ~m_par[i];
      e.tick[i] = tk;
      e.run[i]  = m_run[i];
`ifdef OSC_TICK_GEN_CLKOUT_EN
      e.clk[i]  = m_par[i];
`else
      e.clk[i]  = 1'b0;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, $urandom_range(3), $urandom_range(255), 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RESETN = 0;
    #1;
    check("rst_tick", 32'(TICK), 0);
    check("rst_running", 32'(RUNNING), 0);
    check("rst_clkout", 32'(CLKOUT), 0);
    repeat (3) @(negedge CLK);
    model_reset();
    RESETN = 1;
  endtask

  // Monitor: every registered output set the DUT presents is matched to the scoreboard.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge CLK); #1;
      if (RESETN && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {TICK, RUNNING, CLKOUT};
        check("outputs", 32'(a), 32'(e));
      end
    end
  end

  int divs[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 17, 255};

  initial begin
    CFG_VALID = 0; CFG_CH = '0; CFG_DIV = '0; CFG_EN = 0;
    RESETN = 1;
    model_reset();
    do_reset();

    idle(3000);

    step(1, 0, 5, 1);
    idle(20);

    step(1, 1, 10, 1);
    idle(13);
    step(1, 1, 3, 1);
    repeat (8) step(1, 1, 7, 1);
    idle(20);

    step(1, 2, 0, 1);
    idle(6);
    step(1, 2, 0, 0);
    step(1, 2, 1, 1);
    idle(4);
    step(1, 2, 9, 1);
    step(1, 2, 4, 1);
    step(1, 2, 4, 0);
    step(1, 2, 2, 1);
    idle(8);

    repeat (4) step(1, 3, 4, 1);
    step(1, 3, 4, 0);
    idle(4);

    step(1, 0, 4, 0);
    step(1, 0, 4, 1);
    step(1, 1, 255, 0);
    step(1, 1, 255, 1);
    idle(600);
    step(1, 2, 1, 0);
    step(1, 2, 1, 1);
    idle(7);
    do_reset();
    idle(300);

    for (int k = 0; k < 3000; k++)
      step(($urandom_range(3) == 0), $urandom_range(3), divs[$urandom_range(13)],
           ($urandom_range(4) != 0));
    idle(5);

    @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
